// File: rtl/core_pkg.sv
// Shared core encodings: ALU op classes, writeback source selects and the
// decoded control word produced by ControlUnit.
package core_pkg;

  typedef enum logic [2:0] {
    ALUOP_MEM = 3'b000,
    ALUOP_BR  = 3'b001,
    ALUOP_R   = 3'b010,
    ALUOP_NOP = 3'b011,
    ALUOP_I   = 3'b110,
    ALUOP_MD  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU   = 2'b00,
    WB_PC4   = 2'b01,
    WB_AUIPC = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic    branch;
    logic    jump;
    logic    mem_read;
    logic    mem_to_reg;
    logic    mem_write;
    logic    alu_src;
    logic    reg_write;
    logic    pc_mux_sel1;
    alu_op_e alu_op;
    wb_sel_e reg_file_mux_sel;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side fields in, registered EX-side fields and
// fetch enables / debug counters out.
interface id_ex_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);

  logic            id_valid;
  logic            id_branch;
  logic            id_jump;
  logic            id_mem_read;
  logic            id_mem_to_reg;
  logic            id_mem_write;
  logic            id_alu_src;
  logic            id_reg_write;
  logic            id_pc_mux_sel1;
  logic [2:0]      id_alu_op;
  logic [1:0]      id_reg_file_mux_sel;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [3:0]      id_funct;
  logic            ex_stall;
  logic            flush;

  logic             ex_valid;
  logic             ex_branch;
  logic             ex_jump;
  logic             ex_mem_read;
  logic             ex_mem_to_reg;
  logic             ex_mem_write;
  logic             ex_alu_src;
  logic             ex_reg_write;
  logic             ex_pc_mux_sel1;
  logic [2:0]       ex_alu_op;
  logic [1:0]       ex_reg_file_mux_sel;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1_data;
  logic [XLEN-1:0]  ex_rs2_data;
  logic [XLEN-1:0]  ex_imm;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic [3:0]       ex_funct;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_branch, id_jump, id_mem_read, id_mem_to_reg, id_mem_write,
           id_alu_src, id_reg_write, id_pc_mux_sel1, id_alu_op, id_reg_file_mux_sel,
           id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct,
           ex_stall, flush,
    input  ex_valid, ex_branch, ex_jump, ex_mem_read, ex_mem_to_reg, ex_mem_write,
           ex_alu_src, ex_reg_write, ex_pc_mux_sel1, ex_alu_op, ex_reg_file_mux_sel,
           ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct,
           pc_write_en, if_id_write_en, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_branch, id_jump, id_mem_read, id_mem_to_reg, id_mem_write,
           id_alu_src, id_reg_write, id_pc_mux_sel1, id_alu_op, id_reg_file_mux_sel,
           id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct,
           ex_stall, flush,
    output ex_valid, ex_branch, ex_jump, ex_mem_read, ex_mem_to_reg, ex_mem_write,
           ex_alu_src, ex_reg_write, ex_pc_mux_sel1, ex_alu_op, ex_reg_file_mux_sel,
           ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct,
           pc_write_en, if_id_write_en, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register a
// load currently in EX is about to write.
module hazard_detect
  import core_pkg::*;
(
  input  logic       id_valid,
  input  logic [2:0] id_alu_op,
  input  logic [1:0] id_reg_file_mux_sel,
  input  logic       id_alu_src,
  input  logic       id_mem_write,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hazard_o
);

  logic use_rs1;
  logic use_rs2;

  // lui-style (NOP op class) and auipc-style writeback never read rs1; stores
  // read rs2 even though their ALU operand is the immediate.
  assign use_rs1 = id_valid & (id_alu_op != ALUOP_NOP) & (id_reg_file_mux_sel != WB_AUIPC);
  assign use_rs2 = id_valid & (~id_alu_src | id_mem_write);

  assign hazard_o = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((use_rs1 & (ex_rd == id_rs1)) | (use_rs2 & (ex_rd == id_rs2)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds on EX stall, bubbles on load-use hazard,
// clears on flush, and counts stall/flush events.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  ctrl_t            id_ctrl;
  ctrl_t            ctrl_d, ctrl_q;
  logic             valid_d, valid_q;
  logic [XLEN-1:0]  pc_d, pc_q;
  logic [XLEN-1:0]  rs1_data_d, rs1_data_q;
  logic [XLEN-1:0]  rs2_data_d, rs2_data_q;
  logic [XLEN-1:0]  imm_d, imm_q;
  logic [4:0]       rs1_d, rs1_q;
  logic [4:0]       rs2_d, rs2_q;
  logic [4:0]       rd_d, rd_q;
  logic [3:0]       funct_d, funct_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             hazard;

  always_comb begin
    id_ctrl                  = '0;
    id_ctrl.branch           = bus.id_branch;
    id_ctrl.jump             = bus.id_jump;
    id_ctrl.mem_read         = bus.id_mem_read;
    id_ctrl.mem_to_reg       = bus.id_mem_to_reg;
    id_ctrl.mem_write        = bus.id_mem_write;
    id_ctrl.alu_src          = bus.id_alu_src;
    id_ctrl.reg_write        = bus.id_reg_write;
    id_ctrl.pc_mux_sel1      = bus.id_pc_mux_sel1;
    id_ctrl.alu_op           = alu_op_e'(bus.id_alu_op);
    id_ctrl.reg_file_mux_sel = wb_sel_e'(bus.id_reg_file_mux_sel);
  end

  hazard_detect u_hazard_detect (
    .id_valid            (bus.id_valid),
    .id_alu_op           (bus.id_alu_op),
    .id_reg_file_mux_sel (bus.id_reg_file_mux_sel),
    .id_alu_src          (bus.id_alu_src),
    .id_mem_write        (bus.id_mem_write),
    .id_rs1              (bus.id_rs1),
    .id_rs2              (bus.id_rs2),
    .ex_valid            (valid_q),
    .ex_mem_read         (ctrl_q.mem_read),
    .ex_rd               (rd_q),
    .hazard_o            (hazard)
  );

  // Priority: flush, then stall-hold, then hazard bubble, then normal load.
  always_comb begin
    ctrl_d      = ctrl_q;
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    funct_d     = funct_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.flush || (!bus.ex_stall && hazard)) begin
      ctrl_d     = '0;
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      funct_d    = '0;
      if (bus.flush) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else if (!bus.ex_stall) begin
      ctrl_d     = id_ctrl;
      valid_d    = bus.id_valid;
      pc_d       = bus.id_pc;
      rs1_data_d = bus.id_rs1_data;
      rs2_data_d = bus.id_rs2_data;
      imm_d      = bus.id_imm;
      rs1_d      = bus.id_rs1;
      rs2_d      = bus.id_rs2;
      rd_d       = bus.id_rd;
      funct_d    = bus.id_funct;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= '0;
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      funct_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      funct_q     <= funct_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Flush must still let fetch redirect even while EX is busy.
  assign bus.pc_write_en    = ~(bus.ex_stall | hazard) | bus.flush;
  assign bus.if_id_write_en = ~(bus.ex_stall | hazard) | bus.flush;

  assign bus.ex_valid            = valid_q;
  assign bus.ex_branch           = ctrl_q.branch;
  assign bus.ex_jump             = ctrl_q.jump;
  assign bus.ex_mem_read         = ctrl_q.mem_read;
  assign bus.ex_mem_to_reg       = ctrl_q.mem_to_reg;
  assign bus.ex_mem_write        = ctrl_q.mem_write;
  assign bus.ex_alu_src          = ctrl_q.alu_src;
  assign bus.ex_reg_write        = ctrl_q.reg_write;
  assign bus.ex_pc_mux_sel1      = ctrl_q.pc_mux_sel1;
  assign bus.ex_alu_op           = ctrl_q.alu_op;
  assign bus.ex_reg_file_mux_sel = ctrl_q.reg_file_mux_sel;
  assign bus.ex_pc               = pc_q;
  assign bus.ex_rs1_data         = rs1_data_q;
  assign bus.ex_rs2_data         = rs2_data_q;
  assign bus.ex_imm              = imm_q;
  assign bus.ex_rs1              = rs1_q;
  assign bus.ex_rs2              = rs2_q;
  assign bus.ex_rd               = rd_q;
  assign bus.ex_funct            = funct_q;
  assign bus.stall_count         = stall_cnt_q;
  assign bus.flush_count         = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a per-instruction
// reference model of the ID/EX slot and its event counters.
module tb_id_ex_stage;
  import core_pkg::*;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  funct;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  instr_t      exp_ex = '0;
  logic [31:0] exp_sc = '0;
  logic [31:0] exp_fc = '0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .CNT_W(32)) bus ();

  id_ex_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input instr_t in);
    bus.id_valid            = in.valid;
    bus.id_branch           = in.ctrl.branch;
    bus.id_jump             = in.ctrl.jump;
    bus.id_mem_read         = in.ctrl.mem_read;
    bus.id_mem_to_reg       = in.ctrl.mem_to_reg;
    bus.id_mem_write        = in.ctrl.mem_write;
    bus.id_alu_src          = in.ctrl.alu_src;
    bus.id_reg_write        = in.ctrl.reg_write;
    bus.id_pc_mux_sel1      = in.ctrl.pc_mux_sel1;
    bus.id_alu_op           = in.ctrl.alu_op;
    bus.id_reg_file_mux_sel = in.ctrl.reg_file_mux_sel;
    bus.id_pc               = in.pc;
    bus.id_rs1_data         = in.rs1_data;
    bus.id_rs2_data         = in.rs2_data;
    bus.id_imm              = in.imm;
    bus.id_rs1              = in.rs1;
    bus.id_rs2              = in.rs2;
    bus.id_rd               = in.rd;
    bus.id_funct            = in.funct;
  endtask

  function automatic instr_t get_ex();
    instr_t e;
    e.valid                 = bus.ex_valid;
    e.ctrl.branch           = bus.ex_branch;
    e.ctrl.jump             = bus.ex_jump;
    e.ctrl.mem_read         = bus.ex_mem_read;
    e.ctrl.mem_to_reg       = bus.ex_mem_to_reg;
    e.ctrl.mem_write        = bus.ex_mem_write;
    e.ctrl.alu_src          = bus.ex_alu_src;
    e.ctrl.reg_write        = bus.ex_reg_write;
    e.ctrl.pc_mux_sel1      = bus.ex_pc_mux_sel1;
    e.ctrl.alu_op           = alu_op_e'(bus.ex_alu_op);
    e.ctrl.reg_file_mux_sel = wb_sel_e'(bus.ex_reg_file_mux_sel);
    e.pc                    = bus.ex_pc;
    e.rs1_data              = bus.ex_rs1_data;
    e.rs2_data              = bus.ex_rs2_data;
    e.imm                   = bus.ex_imm;
    e.rs1                   = bus.ex_rs1;
    e.rs2                   = bus.ex_rs2;
    e.rd                    = bus.ex_rd;
    e.funct                 = bus.ex_funct;
    return e;
  endfunction

  // Does the instruction in ID need the value a load in EX has not yet produced?
  function automatic bit needs_load_result(input instr_t ex, input instr_t id);
    bit reads1, reads2;
    if (!(ex.valid && ex.ctrl.mem_read && ex.rd != 5'd0)) return 1'b0;
    reads1 = id.valid && id.ctrl.alu_op != ALUOP_NOP && id.ctrl.reg_file_mux_sel != WB_AUIPC;
    reads2 = id.valid && (!id.ctrl.alu_src || id.ctrl.mem_write);
    return (reads1 && ex.rd == id.rs1) || (reads2 && ex.rd == id.rs2);
  endfunction

  // One clock: drive at negedge, check enables, advance model, check EX slot.
  task automatic step(input instr_t in, input bit stall, input bit fl, input bit r);
    bit h, en;
    drive(in);
    bus.ex_stall = stall;
    bus.flush    = fl;
    rst          = r;
    #1;
    h  = needs_load_result(exp_ex, in);
    en = !(stall || h) || fl;
    check("pc_write_en", 192'(bus.pc_write_en), 192'(en));
    check("if_id_write_en", 192'(bus.if_id_write_en), 192'(en));
    if (r) begin
      exp_ex = '0; exp_sc = '0; exp_fc = '0;
    end else if (fl) begin
      exp_ex = '0; exp_fc = exp_fc + 1;
    end else if (!stall) begin
      if (h) begin
        exp_ex = '0; exp_sc = exp_sc + 1;
      end else begin
        exp_ex = in;
      end
    end
    @(posedge clk);
    #1;
    check("ex_slot", 192'(get_ex()), 192'(exp_ex));
    check("counters", 192'({bus.stall_count, bus.flush_count}), 192'({exp_sc, exp_fc}));
    @(negedge clk);
  endtask

  function automatic instr_t mk_r(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] d1,
                                  input logic [31:0] d2);
    instr_t i = '0;
    i.valid = 1'b1; i.ctrl.reg_write = 1'b1; i.ctrl.alu_op = ALUOP_R;
    i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.rs1_data = d1; i.rs2_data = d2;
    i.pc = 32'h100;
    return i;
  endfunction

  function automatic instr_t mk_lw(input logic [4:0] rd, input logic [4:0] rs1);
    instr_t i = '0;
    i.valid = 1'b1; i.ctrl.reg_write = 1'b1; i.ctrl.mem_read = 1'b1;
    i.ctrl.mem_to_reg = 1'b1; i.ctrl.alu_src = 1'b1; i.ctrl.alu_op = ALUOP_MEM;
    i.rd = rd; i.rs1 = rs1; i.rs2 = 5'd5; i.imm = 32'h10; i.funct = 4'b0010;
    return i;
  endfunction

  function automatic instr_t mk_random();
    instr_t i;
    i.ctrl          = ctrl_t'($urandom);
    i.ctrl.alu_op   = alu_op_e'($urandom_range(0, 7));
    i.ctrl.mem_read = ($urandom_range(0, 1) == 0);
    i.valid         = ($urandom_range(0, 9) != 0);
    i.pc            = $urandom;
    i.rs1_data      = $urandom;
    i.rs2_data      = $urandom;
    i.imm           = $urandom;
    i.rs1           = 5'($urandom_range(0, 3));
    i.rs2           = 5'($urandom_range(0, 3));
    i.rd            = 5'($urandom_range(0, 3));
    i.funct         = 4'($urandom);
    return i;
  endfunction

  initial begin
    instr_t add3, lw5, add6, lui5, lw0, add0, sw;
    bus.ex_stall = 1'b1;
    bus.flush    = 1'b1;
    drive(mk_random());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.ex_stall = 1'b0;
    bus.flush    = 1'b0;
    #1;
    check("reset_ex_slot", 192'(get_ex()), 192'(0));
    check("reset_enables", 192'({bus.pc_write_en, bus.if_id_write_en}), 192'(2'b11));
    check("reset_counters", 192'({bus.stall_count, bus.flush_count}), 192'(0));
    @(negedge clk);

    add3 = mk_r(5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
    step(add3, 0, 0, 0);
    check("pass_alu_op", 192'(bus.ex_alu_op), 192'(3'b010));
    check("pass_rd", 192'(bus.ex_rd), 192'(5'd3));
    check("pass_rs1_data", 192'(bus.ex_rs1_data), 192'(32'd5));
    check("pass_valid", 192'(bus.ex_valid), 192'(1'b1));

    lw5  = mk_lw(5'd5, 5'd2);
    add6 = mk_r(5'd6, 5'd5, 5'd1, 32'd9, 32'd4);
    step(lw5, 0, 0, 0);
    step(add6, 0, 0, 0);
    check("lu_bubble_valid", 192'(bus.ex_valid), 192'(1'b0));
    check("lu_bubble_reg_write", 192'(bus.ex_reg_write), 192'(1'b0));
    check("lu_stall_count", 192'(bus.stall_count), 192'(1));
    step(add6, 0, 0, 0);
    check("lu_add_in_ex", 192'(bus.ex_rd), 192'(5'd6));

    lui5 = '0;
    lui5.valid = 1'b1; lui5.ctrl.reg_write = 1'b1; lui5.ctrl.alu_src = 1'b1;
    lui5.ctrl.alu_op = ALUOP_NOP; lui5.rd = 5'd5; lui5.rs1 = 5'd5; lui5.rs2 = 5'd5;
    step(lw5, 0, 0, 0);
    step(lui5, 0, 0, 0);
    check("lui_no_stall", 192'(bus.stall_count), 192'(1));

    lw0  = mk_lw(5'd0, 5'd1);
    add0 = mk_r(5'd1, 5'd0, 5'd0, 32'd0, 32'd0);
    step(lw0, 0, 0, 0);
    step(add0, 0, 0, 0);
    check("x0_no_stall", 192'(bus.stall_count), 192'(1));
    check("x0_add_in_ex", 192'(bus.ex_rd), 192'(5'd1));

    sw = '0;
    sw.valid = 1'b1; sw.ctrl.mem_write = 1'b1; sw.ctrl.alu_src = 1'b1;
    sw.rs1 = 5'd2; sw.rs2 = 5'd3; sw.imm = 32'h8;
    step(sw, 0, 1, 0);
    check("flush_mem_write", 192'(bus.ex_mem_write), 192'(1'b0));
    check("flush_valid", 192'(bus.ex_valid), 192'(1'b0));
    check("flush_count", 192'(bus.flush_count), 192'(1));

    step(lw5, 0, 0, 0);
    repeat (3) step(add6, 1, 0, 0);
    check("hold_rd", 192'(bus.ex_rd), 192'(5'd5));
    check("hold_mem_read", 192'(bus.ex_mem_read), 192'(1'b1));
    check("hold_stall_count", 192'(bus.stall_count), 192'(1));
    step(add6, 1, 1, 0);
    check("stall_flush_valid", 192'(bus.ex_valid), 192'(1'b0));
    check("stall_flush_count", 192'(bus.flush_count), 192'(2));

    step(lw5, 0, 0, 0);
    step(add6, 1, 0, 1);
    check("rst_mid_stall", 192'({bus.stall_count, bus.flush_count}), 192'(0));

    for (int n = 0; n < 400; n++) begin
      step(mk_random(), $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with a built-in load-use hazard detector for the 5-stage RV32 core. It captures the decode-stage control word (from `ControlUnit`) and operands each cycle, and handles three cases: holds on an EX-side stall, inserts a bubble on a load-use hazard, and clears on a taken branch/jump flush. It also drives PC and IF/ID write enables and keeps two 32-bit event counters for performance debug.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `CNT_W`, 32, width of stall/flush event counters.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_branch, id_jump, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_pc_mux_sel1`  in  1 each  control bits from ControlUnit.
- `id_alu_op`  in  3  ALU op class.
- `id_reg_file_mux_sel`  in  2  writeback source select.
- `id_pc, id_rs1_data, id_rs2_data, id_imm`  in  XLEN  operands.
- `id_rs1, id_rs2, id_rd`  in  5  register indices.
- `id_funct`  in  4  {inst[30], inst[14:12]}.
- `ex_stall`  in  1  EX busy (multicycle mul/div); hold everything.
- `flush`  in  1  taken branch/jump resolved; kill ID/EX contents.
- `ex_*`  out  same widths as `id_*` counterparts, plus `ex_valid`  registered ID/EX contents.
- `pc_write_en`  out  1  PC may advance.
- `if_id_write_en`  out  1  IF/ID may load.
- `stall_count, flush_count`  out  CNT_W  event counters.

## Operation
- Source use: `use_rs1 = id_valid & (id_alu_op != 3'b011) & (id_reg_file_mux_sel != 2'b10)`.
- `use_rs2 = id_valid & (~id_alu_src | id_mem_write)`.
- Load-use: `hazard = ex_valid & ex_mem_read & (ex_rd != 0) & ((use_rs1 & ex_rd==id_rs1) | (use_rs2 & ex_rd==id_rs2))`.
- Register update priority, evaluated every cycle:
  1. `rst`: all `ex_*` = 0, `ex_valid` = 0, counters = 0.
  2. `flush`: bubble. All control outputs 0, `ex_valid` = 0; data fields don't-care (load 0). `flush_count` +1.
  3. `ex_stall`: hold all `ex_*`.
  4. `hazard`: bubble as in (2). `stall_count` +1.
  5. Otherwise: load all `id_*` into `ex_*`.
- Bubble means every control bit (`ex_reg_write`, `ex_mem_write`, `ex_mem_read`, `ex_branch`, `ex_jump`, `ex_pc_mux_sel1`) is 0, `ex_alu_op` = 000 and `ex_reg_file_mux_sel` = 00.
- `pc_write_en = if_id_write_en = ~(ex_stall | hazard) | flush`. These are combinational from current state and inputs. `flush` overrides so fetch can redirect.
- Counters wrap modulo 2^CNT_W. They do not saturate.

## Timing
- Latency is one cycle from ID to EX.
- `hazard` asserts in the same cycle the dependent instruction is in ID. The dependent instruction waits exactly one cycle, then enters EX.
- `ex_stall` and `hazard` together: hold wins. No bubble is inserted and no stall is counted. The hazard is re-evaluated next cycle.
- `flush` and `ex_stall` together: flush wins. The ID/EX contents are cleared.
- Back-to-back loads each producing a hazard cause a separate one-cycle bubble each.
- `rst` asserted mid-stall or mid-flush clears state on that edge. Enables are 1 after reset because `ex_valid` = 0.
- Reset values: all `ex_*` 0, `ex_valid` 0, counters 0, `pc_write_en` 1, `if_id_write_en` 1.

## Structure
- Shared package `core_pkg` holds:
  - ALUOp encodings: `ALUOP_MEM`=000, `ALUOP_BR`=001, `ALUOP_R`=010, `ALUOP_NOP`=011, `ALUOP_I`=110, `ALUOP_MD`=111.
  - RegFileMuxSel encodings: `WB_ALU`=00, `WB_PC4`=01, `WB_AUIPC`=10.
  - A packed `ctrl_t` struct of the ControlUnit outputs.
- One sub-module: `hazard_detect`, combinational. It computes `use_rs1`/`use_rs2`/`hazard`. The register and counters stay in `id_ex_stage`.

## Test plan
- Reset: hold `rst` 2 cycles with arbitrary `id_*` -> all `ex_*` 0, `ex_valid` 0, enables 1, counters 0.
- Pass-through: `add x3,x1,x2` (alu_op 010, reg_write 1, rd 3, rs1_data 5, rs2_data 7) -> next cycle `ex_alu_op`=010, `ex_rd`=3, `ex_rs1_data`=5, `ex_valid`=1.
- Load-use: `lw x5` in EX, `add x6,x5,x1` in ID -> enables 0 for one cycle, bubble in EX, `stall_count`=1. Next cycle the add is in EX.
- No false stall:
  - `lw x5` in EX, `lui x5` in ID -> no hazard.
  - `lw x0` in EX, `add x1,x0,x0` in ID -> no hazard.
- Flush: `flush`=1 with a valid `sw` in ID -> `ex_mem_write`=0, `ex_valid`=0, `flush_count`=1, enables 1.
- Stall priority:
  - `ex_stall`=1 for 3 cycles with a hazard present -> `ex_*` unchanged, `stall_count` unchanged.
  - Then assert `flush` while `ex_stall`=1 -> cleared.
